// File: rtl/pwr_seq_ctrl_if.sv
// Board power-sequencing bus: raw power-good / request inputs from the board
// and the decoded control-state outputs consumed by the reset/DC-OK blocks.
interface pwr_seq_ctrl_if;
  logic       i_sby_pg;
  logic       i_work_pg;
  logic       i_all_pg;
  logic       i_on_req;
  logic       i_off_req;
  logic [3:0] o_ctrl_state;
  logic       o_ps_on;
  logic       o_pcie_rst_n;
  logic       o_ich_dcok;
  logic       o_ich_pwrgd;
  logic       o_cpu_dcok;
  logic       o_fault;
  logic [1:0] o_fault_code;

  // Board side: drives power-good/requests, observes the sequencer
  modport master (
    output i_sby_pg, i_work_pg, i_all_pg, i_on_req, i_off_req,
    input  o_ctrl_state, o_ps_on, o_pcie_rst_n, o_ich_dcok, o_ich_pwrgd,
    input  o_cpu_dcok, o_fault, o_fault_code
  );

  // Sequencer side
  modport slave (
    input  i_sby_pg, i_work_pg, i_all_pg, i_on_req, i_off_req,
    output o_ctrl_state, o_ps_on, o_pcie_rst_n, o_ich_dcok, o_ich_pwrgd,
    output o_cpu_dcok, o_fault, o_fault_code
  );
endinterface

// File: rtl/pwr_seq_ctrl.sv
// Board power-sequencing controller. Walks the 4-bit control state from
// standby through PS_ON, PG checks, reset release and DC-OK phases to End,
// timing each phase with one saturating counter on the 32 kHz clock and
// falling back to SbyEnd/Sby on faults, off requests or standby loss.
module pwr_seq_ctrl #(
  parameter int T_STEP  = 16,
  parameter int T_RST   = 3277,
  parameter int T_PG_TO = 16384,
  parameter int TMR_W   = 16
) (
  input  logic         i_clk_32k,
  input  logic         i_rst,
  pwr_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    ST_START        = 4'd0,
    ST_SBY          = 4'd1,
    ST_SBY_END      = 4'd2,
    ST_PS_ON        = 4'd3,
    ST_WORK_PG      = 4'd4,
    ST_ALL_PG       = 4'd5,
    ST_T5_RST       = 4'd6,
    ST_T5_RST_END   = 4'd7,
    ST_PCIE_RST_END = 4'd8,
    ST_ICH_DCOK     = 4'd9,
    ST_ICH_PWRGD    = 4'd10,
    ST_CPU_DCOK     = 4'd11,
    ST_END          = 4'd12
  } state_e;

  localparam logic [1:0] FC_WORK_TO = 2'b01;
  localparam logic [1:0] FC_ALL_TO  = 2'b10;
  localparam logic [1:0] FC_PG_LOST = 2'b11;

  // A dwell of D clocks ends on the edge where the timer reads D-1
  localparam logic [TMR_W-1:0] STEP_LAST = TMR_W'(T_STEP - 1);
  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(T_RST - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(T_PG_TO - 1);

  logic [4:0]       async_in;
  logic [4:0]       sync_p0;
  logic [4:0]       sync_p1;
  logic             sby_s, work_s, all_s, on_s, off_s;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic             fault_d;
  logic [1:0]       code_q, code_d;
  logic             ps_on_q, pcie_rst_n_q, ich_dcok_q, ich_pwrgd_q, cpu_dcok_q;
  logic             fault_q;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  function automatic logic [TMR_W-1:0] dwell_last(input state_e st);
    return (st == ST_T5_RST) ? RST_LAST : STEP_LAST;
  endfunction

  assign async_in = {bus.i_sby_pg, bus.i_work_pg, bus.i_all_pg,
                     bus.i_on_req, bus.i_off_req};

  assign sby_s  = sync_p1[4];
  assign work_s = sync_p1[3];
  assign all_s  = sync_p1[2];
  assign on_s   = sync_p1[1];
  assign off_s  = sync_p1[0];

  // Two-flop synchroniser for every asynchronous board input
  always_ff @(posedge i_clk_32k or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
    end
  end

  // Next-state rules: standby loss beats off request beats PG fault beats progress
  always_comb begin
    state_d = state_q;
    fault_d = 1'b0;
    code_d  = code_q;
    case (state_q)
      ST_START: state_d = ST_SBY;
      ST_SBY: begin
        if (sby_s) state_d = ST_SBY_END;
      end
      ST_SBY_END: begin
        if (!sby_s) begin
          state_d = ST_SBY;
        end else if (on_s && !off_s) begin
          state_d = ST_PS_ON;
          code_d  = 2'b00;
        end
      end
      ST_PS_ON, ST_WORK_PG, ST_ALL_PG, ST_T5_RST, ST_T5_RST_END,
      ST_PCIE_RST_END, ST_ICH_DCOK, ST_ICH_PWRGD, ST_CPU_DCOK, ST_END: begin
        if (!sby_s) begin
          state_d = ST_SBY;
        end else if (off_s) begin
          state_d = ST_SBY_END;
        end else if (state_q == ST_PS_ON) begin
          // PG arriving on the expiry cycle still wins over the timeout
          if (work_s) begin
            state_d = ST_WORK_PG;
          end else if (timer_q == TO_LAST) begin
            state_d = ST_SBY_END;
            fault_d = 1'b1;
            code_d  = FC_WORK_TO;
          end
        end else if (state_q == ST_WORK_PG) begin
          if (all_s) begin
            state_d = ST_ALL_PG;
          end else if (timer_q == TO_LAST) begin
            state_d = ST_SBY_END;
            fault_d = 1'b1;
            code_d  = FC_ALL_TO;
          end
        end else if (!work_s || !all_s) begin
          state_d = ST_SBY_END;
          fault_d = 1'b1;
          code_d  = FC_PG_LOST;
        end else if (state_q != ST_END && timer_q == dwell_last(state_q)) begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
      default: state_d = ST_SBY;
    endcase
  end

  // State, timer and outputs; outputs decode the next state so they move with o_ctrl_state
  always_ff @(posedge i_clk_32k or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_START;
      timer_q      <= '0;
      code_q       <= 2'b00;
      fault_q      <= 1'b0;
      ps_on_q      <= 1'b0;
      pcie_rst_n_q <= 1'b0;
      ich_dcok_q   <= 1'b0;
      ich_pwrgd_q  <= 1'b0;
      cpu_dcok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= (state_d != state_q) ? '0 : sat_inc(timer_q);
      code_q       <= code_d;
      fault_q      <= fault_d;
      ps_on_q      <= (state_d >= ST_PS_ON)        && (state_d <= ST_END);
      pcie_rst_n_q <= (state_d >= ST_PCIE_RST_END) && (state_d <= ST_END);
      ich_dcok_q   <= (state_d >= ST_ICH_DCOK)     && (state_d <= ST_END);
      ich_pwrgd_q  <= (state_d >= ST_ICH_PWRGD)    && (state_d <= ST_END);
      cpu_dcok_q   <= (state_d >= ST_CPU_DCOK)     && (state_d <= ST_END);
    end
  end

  assign bus.o_ctrl_state = state_q;
  assign bus.o_ps_on      = ps_on_q;
  assign bus.o_pcie_rst_n = pcie_rst_n_q;
  assign bus.o_ich_dcok   = ich_dcok_q;
  assign bus.o_ich_pwrgd  = ich_pwrgd_q;
  assign bus.o_cpu_dcok   = cpu_dcok_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_fault_code = code_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Testbench for pwr_seq_ctrl: vector table for the nominal power-up and abort
// paths, hand-written timeout / reset corner sequences, then random board
// activity checked against a rule-level reference model.
module tb_pwr_seq_ctrl;
  localparam int T_STEP  = 4;
  localparam int T_RST   = 8;
  localparam int T_PG_TO = 20;
  localparam int TMR_W   = 16;
  localparam int TMAX    = (1 << TMR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pwr_seq_ctrl_if bus();

  pwr_seq_ctrl #(
    .T_STEP(T_STEP), .T_RST(T_RST), .T_PG_TO(T_PG_TO), .TMR_W(TMR_W)
  ) dut (
    .i_clk_32k(clk),
    .i_rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Output levels implied by a state code
  function automatic logic [4:0] exp_outs(input int st);
    logic [4:0] o;
    o[4] = (st >= 3)  && (st <= 12);
    o[3] = (st >= 8)  && (st <= 12);
    o[2] = (st >= 9)  && (st <= 12);
    o[1] = (st >= 10) && (st <= 12);
    o[0] = (st >= 11) && (st <= 12);
    return o;
  endfunction

  function automatic logic [11:0] mk_exp(input int st, input logic flt, input logic [1:0] code);
    return {4'(st), exp_outs(st), flt, code};
  endfunction

  function logic [11:0] dut_bundle();
    return {bus.o_ctrl_state, bus.o_ps_on, bus.o_pcie_rst_n, bus.o_ich_dcok,
            bus.o_ich_pwrgd, bus.o_cpu_dcok, bus.o_fault, bus.o_fault_code};
  endfunction

  task automatic set_in(input logic s, input logic w, input logic a,
                        input logic on, input logic off);
    bus.i_sby_pg  = s;
    bus.i_work_pg = w;
    bus.i_all_pg  = a;
    bus.i_on_req  = on;
    bus.i_off_req = off;
  endtask

  // Reference model: state number, clocks spent in it, sticky code,
  // and a queue delaying the board inputs by the two-clock sampling latency.
  int         m_st, m_age, m_code;
  logic       m_flt;
  logic [4:0] hist[$];

  function automatic int dwell(input int st);
    if (st == 6) return T_RST;
    if (st == 5 || (st >= 7 && st <= 11)) return T_STEP;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_age = 0; m_code = 0; m_flt = 1'b0;
    hist.delete();
    hist.push_back(5'd0);
    hist.push_back(5'd0);
  endtask

  task automatic model_step();
    logic [4:0] s;
    logic sby, work, all, on, off;
    int nxt;
    hist.push_back({bus.i_sby_pg, bus.i_work_pg, bus.i_all_pg, bus.i_on_req, bus.i_off_req});
    s = hist.pop_front();
    {sby, work, all, on, off} = s;
    nxt = m_st;
    m_flt = 1'b0;
    if (m_st == 0) nxt = 1;
    else if (m_st == 1) begin
      if (sby) nxt = 2;
    end else if (m_st == 2) begin
      if (!sby) nxt = 1;
      else if (on && !off) begin nxt = 3; m_code = 0; end
    end else if (m_st <= 12) begin
      if (!sby) nxt = 1;
      else if (off) nxt = 2;
      else if (m_st == 3) begin
        if (work) nxt = 4;
        else if (m_age == T_PG_TO - 1) begin nxt = 2; m_flt = 1'b1; m_code = 1; end
      end else if (m_st == 4) begin
        if (all) nxt = 5;
        else if (m_age == T_PG_TO - 1) begin nxt = 2; m_flt = 1'b1; m_code = 2; end
      end else if (!work || !all) begin
        nxt = 2; m_flt = 1'b1; m_code = 3;
      end else if (m_st < 12 && m_age == dwell(m_st) - 1) nxt = m_st + 1;
    end else nxt = 1;
    if (nxt != m_st) m_age = 0;
    else if (m_age < TMAX) m_age++;
    m_st = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else model_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) tick();
  endtask

  typedef struct {
    logic s, w, a, on, off;
    int   n;
    int   st;
    logic flt;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic s, input logic w, input logic a,
                              input logic on, input logic off, input int n,
                              input int st, input logic flt, input logic [1:0] code);
    vec_t v;
    v.s = s; v.w = w; v.a = a; v.on = on; v.off = off;
    v.n = n; v.st = st; v.flt = flt; v.code = code;
    return v;
  endfunction

  logic any_flt;

  initial begin
    // Nominal power-up, PG loss, off-request abort, standby loss
    tbl.push_back(mk(1,0,0,0,0, 1,  1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 2,  2,0,0));
    tbl.push_back(mk(1,0,0,1,0, 2,  2,0,0));
    tbl.push_back(mk(1,0,0,1,0, 1,  3,0,0));
    tbl.push_back(mk(1,0,0,1,0, 4,  3,0,0));
    tbl.push_back(mk(1,1,0,1,0, 2,  3,0,0));
    tbl.push_back(mk(1,1,0,1,0, 1,  4,0,0));
    tbl.push_back(mk(1,1,1,1,0, 2,  4,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  5,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3,  5,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  6,0,0));
    tbl.push_back(mk(1,1,1,1,0, 7,  6,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  7,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3,  7,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  8,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3,  8,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  9,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3,  9,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1, 10,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3, 10,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1, 11,0,0));
    tbl.push_back(mk(1,1,1,1,0, 3, 11,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1, 12,0,0));
    tbl.push_back(mk(1,1,1,1,0,10, 12,0,0));
    tbl.push_back(mk(1,1,0,0,0, 2, 12,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1,  2,1,3));
    tbl.push_back(mk(1,1,0,0,0, 1,  2,0,3));
    tbl.push_back(mk(1,1,1,1,0, 2,  2,0,3));
    tbl.push_back(mk(1,1,1,1,0, 1,  3,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  4,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  5,0,0));
    tbl.push_back(mk(1,1,1,1,0,32, 12,0,0));
    tbl.push_back(mk(1,1,0,1,1, 2, 12,0,0));
    tbl.push_back(mk(1,1,0,1,1, 1,  2,0,0));
    tbl.push_back(mk(1,1,0,1,1, 1,  2,0,0));
    tbl.push_back(mk(1,1,1,1,0, 2,  2,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  3,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  4,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  5,0,0));
    tbl.push_back(mk(1,1,1,1,0, 4,  6,0,0));
    tbl.push_back(mk(1,1,1,1,0, 2,  6,0,0));
    tbl.push_back(mk(0,1,1,1,0, 2,  6,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,  1,0,0));
    tbl.push_back(mk(0,1,1,1,0, 1,  1,0,0));
    tbl.push_back(mk(1,1,1,1,0, 2,  1,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  2,0,0));
    tbl.push_back(mk(1,1,1,1,0, 1,  3,0,0));

    set_in(1,0,0,0,0);
    do_reset();
    check("reset_state", 32'(dut_bundle()), 32'(mk_exp(0,0,0)));
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].on, tbl[i].off);
      repeat (tbl[i].n) tick();
      check($sformatf("vec%0d", i), 32'(dut_bundle()),
            32'(mk_exp(tbl[i].st, tbl[i].flt, tbl[i].code)));
    end

    // Work PG timeout: exactly T_PG_TO clocks in PSOn, then one fault pulse
    set_in(1,0,0,1,0);
    do_reset();
    check("to_in_reset", 32'(dut_bundle()), 32'(mk_exp(0,0,0)));
    rst = 1'b0;
    repeat (4) tick();
    check("to_enter_pson", 32'(dut_bundle()), 32'(mk_exp(3,0,0)));
    set_in(1,0,0,0,0);
    any_flt = 1'b0;
    repeat (19) begin tick(); any_flt |= bus.o_fault; end
    check("to_no_early_exit", 32'({any_flt, bus.o_ctrl_state}), 32'({1'b0, 4'd3}));
    tick();
    check("to_fault", 32'(dut_bundle()), 32'(mk_exp(2,1,1)));
    tick();
    check("to_after_pulse", 32'(dut_bundle()), 32'(mk_exp(2,0,1)));

    // Work PG seen on the expiry cycle wins over the timeout
    set_in(1,0,0,1,0);
    repeat (3) tick();
    check("late_reenter", 32'(dut_bundle()), 32'(mk_exp(3,0,0)));
    set_in(1,0,0,0,0);
    any_flt = 1'b0;
    repeat (17) begin tick(); any_flt |= bus.o_fault; end
    set_in(1,1,0,0,0);
    repeat (2) begin tick(); any_flt |= bus.o_fault; end
    check("late_hold", 32'({any_flt, bus.o_ctrl_state}), 32'({1'b0, 4'd3}));
    tick();
    check("late_pg_wins", 32'(dut_bundle()), 32'(mk_exp(4,0,0)));

    // Asynchronous reset from ICH_DCOk
    set_in(1,1,1,0,0);
    repeat (3) tick();
    check("mid_all_pg", 32'(dut_bundle()), 32'(mk_exp(5,0,0)));
    repeat (20) tick();
    check("mid_ich_dcok", 32'(dut_bundle()), 32'(mk_exp(9,0,0)));
    rst = 1'b1;
    #2;
    check("mid_async_rst", 32'(dut_bundle()), 32'(mk_exp(0,0,0)));
    model_reset();

    // Random board activity against the reference model
    set_in(1,0,0,1,0);
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.i_sby_pg  = ~bus.i_sby_pg;
          1: bus.i_work_pg = ~bus.i_work_pg;
          2: bus.i_all_pg  = ~bus.i_all_pg;
          3: bus.i_on_req  = ~bus.i_on_req;
          default: bus.i_off_req = ~bus.i_off_req;
        endcase
      end
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
      check($sformatf("rand%0d", i), 32'(dut_bundle()),
            32'(mk_exp(m_st, m_flt, m_code[1:0])));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
